// File: rtl/w5500_pkg.sv
// Shared types and constants for the W5500 power-up sequencer: register table,
// frame control-byte helper and sequencer state encoding.
package w5500_pkg;

    localparam int NUM_REGS = 6;
    localparam int IDX_W    = $clog2(NUM_REGS + 1);

    localparam logic [15:0] VERSIONR_ADDR = 16'h0039;

    typedef struct packed {
        logic [15:0] addr;
        logic [4:0]  bsb;
        logic [7:0]  data;
    } w5500_reg_t;

    // Common-register block: clear MR, gateway 192.168.1.1, PHY auto-negotiation enabled.
    localparam w5500_reg_t INIT_REGS [NUM_REGS] = '{
        '{addr: 16'h0000, bsb: 5'h00, data: 8'h00},
        '{addr: 16'h0001, bsb: 5'h00, data: 8'hC0},
        '{addr: 16'h0002, bsb: 5'h00, data: 8'hA8},
        '{addr: 16'h0003, bsb: 5'h00, data: 8'h01},
        '{addr: 16'h0004, bsb: 5'h00, data: 8'h01},
        '{addr: 16'h002E, bsb: 5'h00, data: 8'hB8}
    };

    typedef enum logic [3:0] {
        S_RST_ASSERT,
        S_RST_WAIT,
        S_LOAD,
        S_FIRE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_VLOAD,
        S_VFIRE,
        S_VREAD,
        S_VCAP,
        S_DONE,
        S_ERROR
    } w5500_state_t;

    // Variable-length-data-mode control byte: block select, read/write bit, OM=00.
    function automatic logic [7:0] ctrl_byte(input logic [4:0] bsb, input logic rwb);
        return {bsb, rwb, 2'b00};
    endfunction

endpackage

// File: rtl/w5500_frame_push.sv
// Serialises up to four frame bytes into the TX FIFO, holding the current byte
// while the FIFO reports full.
module w5500_frame_push (
    input  logic            clk,
    input  logic            rst,
    input  logic            go,
    input  logic [3:0][7:0] frame,
    input  logic [2:0]      nbytes,
    input  logic            full,
    output logic [7:0]      wdata,
    output logic            wr,
    output logic            frame_done
);

    logic [1:0] ptr;

    assign wr         = go & ~full;
    assign wdata      = go ? frame[ptr] : 8'h00;
    assign frame_done = wr && ({1'b0, ptr} == nbytes - 3'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (!go || frame_done) begin
            ptr <= '0;
        end else if (wr) begin
            ptr <= ptr + 2'd1;
        end
    end

endmodule

// File: rtl/w5500_init_seq.sv
// W5500 power-up sequencer: hardware reset, register-write frames through the
// SPI command path, then a VERSIONR read-back check.
module w5500_init_seq
    import w5500_pkg::*;
#(
    parameter int unsigned DATA           = 8,
    parameter int unsigned RST_CYCLES     = 50000,
    parameter int unsigned WAIT_CYCLES    = 25000000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  VERSION_VAL    = 8'h04
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [DATA-1:0] wdata,
    output logic            wr,
    input  logic            full,
    input  logic [DATA-1:0] rdata,
    output logic            rd,
    input  logic            empty,
    output logic [15:0]     len,
    output logic            op,
    output logic            work,
    input  logic            busy,
    output logic            wrst,
    output logic            done,
    output logic            error
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS);

    w5500_state_t     state, state_n;
    logic [31:0]      cnt, cnt_n;
    logic [IDX_W-1:0] idx, idx_n;

    logic             push_go, frame_done, in_xfer;
    logic [3:0][7:0]  frame;
    logic [2:0]       nbytes;
    logic [7:0]       push_data;
    w5500_reg_t       cur;

    assign in_xfer = (state == S_WAIT_HI) || (state == S_WAIT_LO);
    assign push_go = (state == S_LOAD) || (state == S_VLOAD);

    always_comb begin
        cur    = INIT_REGS[idx];
        frame  = '0;
        nbytes = 3'd4;
        if (state == S_VLOAD) begin
            frame[0] = VERSIONR_ADDR[15:8];
            frame[1] = VERSIONR_ADDR[7:0];
            frame[2] = ctrl_byte(5'b00000, 1'b0);
            nbytes   = 3'd3;
        end else begin
            frame[0] = cur.addr[15:8];
            frame[1] = cur.addr[7:0];
            frame[2] = ctrl_byte(cur.bsb, 1'b1);
            frame[3] = cur.data;
        end
    end

    w5500_frame_push u_push (
        .clk        (clk),
        .rst        (rst),
        .go         (push_go),
        .frame      (frame),
        .nbytes     (nbytes),
        .full       (full),
        .wdata      (push_data),
        .wr         (wr),
        .frame_done (frame_done)
    );

    assign wdata = push_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_RST_ASSERT;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
        end
    end

    // During a transfer cnt holds cycles elapsed since the work pulse, so the
    // timeout fires exactly TIMEOUT_CYCLES after work; a busy edge wins a tie.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        rd      = 1'b0;
        work    = 1'b0;
        case (state)
            S_RST_ASSERT: begin
                if (cnt == RST_CYCLES - 1) begin
                    cnt_n   = '0;
                    state_n = S_RST_WAIT;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            S_RST_WAIT: begin
                if (cnt == WAIT_CYCLES - 1) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = S_LOAD;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            S_LOAD:  if (frame_done) state_n = S_FIRE;
            S_VLOAD: if (frame_done) state_n = S_VFIRE;
            S_FIRE, S_VFIRE: begin
                work    = 1'b1;
                cnt_n   = 32'd1;
                state_n = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                cnt_n = cnt + 32'd1;
                if (busy)                            state_n = S_WAIT_LO;
                else if (cnt == TIMEOUT_CYCLES - 1)  state_n = S_ERROR;
            end
            S_WAIT_LO: begin
                cnt_n = cnt + 32'd1;
                if (!busy) begin
                    if (idx == LAST_IDX) begin
                        state_n = S_VREAD;
                    end else begin
                        idx_n   = idx + 1'b1;
                        state_n = (idx + 1'b1 == LAST_IDX) ? S_VLOAD : S_LOAD;
                    end
                end else if (cnt == TIMEOUT_CYCLES - 1) begin
                    state_n = S_ERROR;
                end
            end
            S_VREAD: begin
                if (!empty) begin
                    rd      = 1'b1;
                    state_n = S_VCAP;
                end
            end
            S_VCAP: state_n = (rdata == VERSION_VAL) ? S_DONE : S_ERROR;
            S_DONE, S_ERROR: begin
                if (start) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = S_RST_ASSERT;
                end
            end
            default: state_n = S_RST_ASSERT;
        endcase
    end

    assign wrst  = (state != S_RST_ASSERT);
    assign len   = ((state == S_FIRE) || (state == S_VFIRE) || in_xfer) ? 16'd4 : 16'd0;
    assign op    = (state == S_FIRE) || (in_xfer && (idx != LAST_IDX));
    assign done  = (state == S_DONE);
    assign error = (state == S_ERROR);

endmodule

// File: tb/tb_w5500_init_seq.sv
// Bench for w5500_init_seq: SPI controller / FIFO models, a per-cycle model
// checker, and directed runs (normal, stall, timeout, bad version, mid-reset).
module tb_w5500_init_seq;

    localparam int RSTC = 10, WAITC = 20, TMO = 100;
    localparam int BUSY_DLY = 2, BUSY_LEN = 40, BUDGET = 3000, NTX = 27;

    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, full = 1'b0, busy = 1'b0, empty = 1'b1;
    logic [7:0]  rdata = 8'h00;
    logic [7:0]  wdata;
    logic        wr, rd, op, work, wrst, done, error;
    logic [15:0] len;

    always #5 clk = ~clk;

    w5500_init_seq #(
        .DATA(8), .RST_CYCLES(RSTC), .WAIT_CYCLES(WAITC),
        .TIMEOUT_CYCLES(TMO), .VERSION_VAL(8'h04)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .wdata(wdata), .wr(wr), .full(full),
        .rdata(rdata), .rd(rd), .empty(empty), .len(len), .op(op), .work(work),
        .busy(busy), .wrst(wrst), .done(done), .error(error)
    );

    int n_cmp = 0, n_fail = 0;
    int unsigned cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected TX byte stream, built from the register list
    logic [15:0] t_addr [6] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h002E};
    logic [7:0]  t_data [6] = '{8'h00, 8'hC0, 8'hA8, 8'h01, 8'h01, 8'hB8};
    logic [7:0]  exp_tx [NTX];

    // ---------------- per-cycle model checker ----------------
    logic        m_done = 0, m_err = 0, clr_next = 0, infl = 0, seen_hi = 0, cur_op = 0;
    logic        first_wr_pend = 1, rise_seen = 0;
    int unsigned w_cyc = 0, phase_start = 0, rise_cyc = 0, wrst_low_n = 0;
    int          tx_pos = 0, work_idx = 0, vstage = 0;
    logic [7:0]  vval = 0;

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_wrst", 32'(wrst), 0);  chk("rst_wr", 32'(wr), 0);
            chk("rst_rd", 32'(rd), 0);      chk("rst_work", 32'(work), 0);
            chk("rst_wdata", 32'(wdata), 0); chk("rst_len", 32'(len), 0);
            chk("rst_op", 32'(op), 0);      chk("rst_done", 32'(done), 0);
            chk("rst_error", 32'(error), 0);
            m_done = 0; m_err = 0; clr_next = 0; infl = 0; vstage = 0;
            tx_pos = 0; work_idx = 0; phase_start = cyc + 1;
            first_wr_pend = 1; wrst_low_n = 0; rise_seen = 0;
        end else begin
            if (clr_next) begin m_done = 0; m_err = 0; clr_next = 0; end
            if (cyc >= phase_start)
                chk("wrst", 32'(wrst), 32'((cyc - phase_start) >= RSTC));
            if (!wrst) begin
                tx_pos = 0; work_idx = 0; wrst_low_n++; first_wr_pend = 1; rise_seen = 0;
            end else if (!rise_seen) begin
                rise_seen = 1; rise_cyc = cyc;
                chk("wrst_low_cycles", wrst_low_n, RSTC);
                wrst_low_n = 0;
            end
            if (infl && (cyc - w_cyc) >= TMO) begin m_err = 1; infl = 0; end
            if (vstage == 1) begin
                vval = rdata; vstage = 2;
            end else if (vstage == 2) begin
                m_done = (vval == 8'h04); m_err = !m_done; vstage = 0;
            end
            chk("done", 32'(done), 32'(m_done));
            chk("error", 32'(error), 32'(m_err));
            if (full) chk("wr_while_full", 32'(wr), 0);
            if (wr) begin
                if (first_wr_pend) begin
                    chk("first_wr_gap", cyc - rise_cyc, WAITC);
                    first_wr_pend = 0;
                end
                chk("tx_byte", 32'(wdata), (tx_pos < NTX) ? 32'(exp_tx[tx_pos]) : 32'h1EE);
                tx_pos++;
            end
            if (work) begin
                cur_op = (work_idx < 6);
                chk("work_op", 32'(op), 32'(cur_op));
                chk("work_len", 32'(len), 4);
                chk("bytes_before_fire", tx_pos, cur_op ? 4 * (work_idx + 1) : NTX);
                infl = 1; seen_hi = 0; w_cyc = cyc; work_idx++;
            end else if (infl) begin
                chk("len_hold", 32'(len), 4);
                chk("op_hold", 32'(op), 32'(cur_op));
                if (busy) seen_hi = 1;
                else if (seen_hi) infl = 0;
            end
            if (rd) begin
                chk("rd_not_empty", 32'(empty), 0);
                vstage = 1;
            end
            if (start && (m_done || m_err)) begin clr_next = 1; phase_start = cyc + 1; end
        end
    end

    // ---------------- controller / FIFO models, driven by main ----------------
    logic        s_wr, s_work, s_op, s_rd, s_done = 0, s_error = 0, s_wrst, s_full;
    logic [7:0]  s_wdata;
    int unsigned s_cyc = 0, xfer_start = 0;
    logic        xfer_pend = 0, xfer_op = 0, busy_en = 1, stall_arm = 0;
    int          stall_left = 0, nw1 = 0, nw0 = 0, full_cyc = 0;
    logic [7:0]  rx_val = 8'h04;
    logic [7:0]  tx_log [$];
    logic [7:0]  rxq [$];

    task automatic tick();
        @(negedge clk);
        s_cyc = cyc; s_wr = wr; s_wdata = wdata; s_work = work; s_op = op; s_rd = rd;
        s_done = done; s_error = error; s_wrst = wrst; s_full = full;
        if (!s_wrst) begin tx_log.delete(); nw1 = 0; nw0 = 0; full_cyc = 0; end
        if (s_wr) tx_log.push_back(s_wdata);
        if (s_full) full_cyc++;
        if (s_work) begin
            if (s_op) nw1++; else nw0++;
            xfer_pend = 1; xfer_op = s_op; xfer_start = s_cyc;
        end
        @(posedge clk); #1; cyc++;
        if (s_rd && rxq.size() > 0) rdata = rxq.pop_front();
        if (xfer_pend && busy_en && !busy && cyc == xfer_start + BUSY_DLY) begin
            busy = 1;
        end else if (busy && cyc == xfer_start + BUSY_DLY + BUSY_LEN) begin
            busy = 0; xfer_pend = 0;
            if (!xfer_op) rxq.push_back(rx_val);
        end
        empty = (rxq.size() == 0);
        if (stall_arm && tx_log.size() == 5) begin stall_left = 5; stall_arm = 0; end
        if (stall_left > 0) begin full = 1; stall_left--; end else full = 0;
    endtask

    task automatic pulse_start();
        start = 1; tick(); start = 0; tick();
    endtask

    task automatic run_to_end(input string name);
        int n = 0;
        while (!(s_done || s_error) && n < BUDGET) begin tick(); n++; end
        if (n >= BUDGET) begin
            n_cmp++; n_fail++;
            $display("FAIL %s: no done/error within %0d cycles", name, BUDGET);
        end
    endtask

    task automatic chk_stream(input string name);
        int diff = 0;
        chk({name, "_len"}, tx_log.size(), NTX);
        for (int i = 0; i < NTX; i++)
            if (i >= tx_log.size() || tx_log[i] !== exp_tx[i]) diff++;
        chk({name, "_diff"}, diff, 0);
    endtask

    initial begin
        for (int i = 0; i < 6; i++) begin
            exp_tx[4*i]     = t_addr[i][15:8];
            exp_tx[4*i + 1] = t_addr[i][7:0];
            exp_tx[4*i + 2] = 8'h04;
            exp_tx[4*i + 3] = t_data[i];
        end
        exp_tx[24] = 8'h00; exp_tx[25] = 8'h39; exp_tx[26] = 8'h00;

        repeat (3) tick();
        rst = 1;

        // Normal run
        run_to_end("run1");
        chk("run1_done", 32'(s_done), 1); chk("run1_error", 32'(s_error), 0);
        chk("run1_wr_frames", nw1, 6);    chk("run1_rd_frames", nw0, 1);
        if (tx_log.size() >= NTX) begin
            chk("tx0", 32'(tx_log[0]), 32'h00); chk("tx1", 32'(tx_log[1]), 32'h00);
            chk("tx2", 32'(tx_log[2]), 32'h04); chk("tx3", 32'(tx_log[3]), 32'h00);
            chk("tx7", 32'(tx_log[7]), 32'hC0); chk("tx25", 32'(tx_log[25]), 32'h39);
            chk("tx26", 32'(tx_log[26]), 32'h00);
        end
        chk_stream("run1_stream");

        // Back-pressure in the middle of frame 2
        stall_arm = 1;
        pulse_start();
        run_to_end("run2");
        chk("run2_done", 32'(s_done), 1);
        chk("run2_full_cycles", full_cyc, 5);
        chk_stream("run2_stream");

        // busy never rises
        busy_en = 0;
        pulse_start();
        run_to_end("run3");
        chk("run3_error", 32'(s_error), 1); chk("run3_done", 32'(s_done), 0);
        chk("run3_timeout_latency", s_cyc - xfer_start, TMO);
        chk("run3_frames", nw1, 1);

        // Wrong version, restart from ERROR
        busy_en = 1; rx_val = 8'h03;
        pulse_start();
        chk("run4_wrst_low", 32'(s_wrst), 0); chk("run4_err_clr", 32'(s_error), 0);
        run_to_end("run4");
        chk("run4_error", 32'(s_error), 1); chk("run4_done", 32'(s_done), 0);

        // Reset during WAIT_LO of frame 3
        rx_val = 8'h04;
        pulse_start();
        begin
            int n = 0;
            while (!(nw1 == 3 && busy) && n < BUDGET) begin tick(); n++; end
            chk("run5_reach_frame3", 32'(n < BUDGET), 1);
        end
        tick();
        rst = 0; #1;
        chk("midrst_wrst", 32'(wrst), 0); chk("midrst_work", 32'(work), 0);
        chk("midrst_wr", 32'(wr), 0);
        busy = 0; xfer_pend = 0; rxq.delete(); empty = 1; full = 0; stall_left = 0;
        repeat (2) tick();
        rst = 1;
        run_to_end("run5");
        chk("run5_done", 32'(s_done), 1); chk("run5_frames", nw1, 6);
        chk_stream("run5_stream");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/w5500_init_seq.md
Name: w5500_init_seq

Overview:
- Power-up configuration sequencer sitting directly upstream of the SPI command path.
- Drives the W5500 hardware reset, then pushes a fixed list of register-write frames into the TX FIFO and launches each transfer via the len/op/work/busy handshake of the SPI controller.
- Finishes by reading back VERSIONR and checking it against the expected value.
- Reports done/error to the rest of the design.

Parameters:
- DATA, 8, FIFO byte width; must be 8.
- RST_CYCLES, 50000, clk cycles wrst is held low.
- WAIT_CYCLES, 25000000, clk cycles after wrst release before the first SPI access (PLL lock).
- TIMEOUT_CYCLES, 1000000, max clk cycles for busy to rise and then fall for one transfer.
- VERSION_VAL, 8'h04, expected VERSIONR content.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; restarts the full sequence when in DONE or ERROR
- wdata  out  DATA  byte to TX FIFO
- wr  out  1  TX FIFO write strobe
- full  in  1  TX FIFO full
- rdata  in  DATA  byte from RX FIFO, valid the cycle after rd
- rd  out  1  RX FIFO read strobe
- empty  in  1  RX FIFO empty
- len  out  16  transfer length in bytes, header included
- op  out  1  1 = write, 0 = read
- work  out  1  one-cycle transfer start pulse
- busy  in  1  SPI controller busy
- wrst  out  1  W5500 reset, active low
- done  out  1  sequence completed and version matched
- error  out  1  timeout or version mismatch

Behaviour:
- Reset (rst=0): state RST_ASSERT, all counters 0, wrst=0, wr=rd=work=0, wdata=0, len=0, op=0, done=0, error=0. After reset release the sequence starts automatically.
- RST_ASSERT: wrst=0 for RST_CYCLES cycles, then wrst=1 and go to RST_WAIT.
- RST_WAIT: count WAIT_CYCLES cycles, then go to LOAD with idx=0.
- LOAD: push 4 bytes in order:
  - addr[15:8]
  - addr[7:0]
  - control = {bsb[4:0], 1'b1, 2'b00}
  - data
  - wr is asserted only in cycles where full=0; when full=1, wr=0 and the byte is held (no loss, no duplicate).
- FIRE: len=4, op=1, work=1 for exactly one cycle. len and op are held stable until busy falls.
- WAIT_HI: wait for busy=1. WAIT_LO: wait for busy=0. Both share one timeout counter, cleared on work. Counter reaching TIMEOUT_CYCLES -> ERROR.
- After busy falls: idx++. If idx==NUM_REGS go to VLOAD, else go to LOAD.
- VLOAD: push 3 header bytes: 8'h00, 8'h39, control {5'b00000, 1'b0, 2'b00}.
- VFIRE: len=4, op=0, work pulse, then WAIT_HI/WAIT_LO as above.
- VREAD: when empty=0, assert rd for 1 cycle; capture rdata the next cycle.
  - Equal to VERSION_VAL -> DONE.
  - Otherwise -> ERROR.
  - A read transfer produces exactly len-3 bytes in the RX FIFO.
- DONE: done=1 (level). ERROR: error=1 (level). Both states are sticky.
- start in DONE/ERROR: clear done/error, go to RST_ASSERT. start in any other state is ignored.
- Simultaneous busy fall and timeout expiry in the same cycle: busy wins, no error.
- Reset mid-transfer: outputs return to reset values immediately. The FIFOs are reset by the same rst, so no stale bytes remain.
- Counter widths: 32 bits. idx width = $clog2(NUM_REGS+1).

Decomposition:
- Package w5500_pkg:
  - typedef w5500_reg_t {logic [15:0] addr; logic [4:0] bsb; logic [7:0] data;}
  - localparam NUM_REGS = 6
  - constant array INIT_REGS:
    - MR=0x0000/0x00
    - GAR0..3 at 0x0001..0x0004
    - RTR-independent PHYCFGR=0x002E/0xB8
  - VERSIONR address constant
  - state enum
- Sub-module w5500_frame_push (byte serializer with full back-pressure) is natural: it takes a 4-byte frame plus a count, returns frame_done, and is used by both LOAD and VLOAD.

Test Plan:
- Reset then release, RST_CYCLES=10, WAIT_CYCLES=20 -> wrst low exactly 10 cycles; first wr exactly 20 cycles after wrst rises.
- Normal run, FIFO never full, controller model pulls busy 2 cycles after work and holds it 40 cycles -> TX bytes 00 00 04 00 first, six op=1 work pulses with len=4, then one op=0 work pulse; RX supplies 0x04 -> done=1, error=0.
- Hold full=1 for 5 cycles in the middle of frame 2 -> no wr during stall; byte sequence identical to the unstalled run.
- busy never rises, TIMEOUT_CYCLES=100 -> error=1 at 100 cycles after work; done stays 0.
- RX returns 0x03 -> error=1; then pulse start -> error clears, wrst goes low again, sequence repeats.
- Assert rst during WAIT_LO of frame 3 -> wrst=0, work=0, wr=0 immediately; after release the full sequence restarts from idx 0.
